// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the multiplexed seven-segment clock display.
package seg_scan_pkg;

    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned POS_N   = 8;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [IDX_W-1:0]   idx_t;

    // Display positions; digit positions double as set-mode select codes.
    localparam idx_t POS_SEC_D  = 3'd0;
    localparam idx_t POS_SEC_G  = 3'd1;
    localparam idx_t POS_SEP_LO = 3'd2;
    localparam idx_t POS_MIN_D  = 3'd3;
    localparam idx_t POS_MIN_G  = 3'd4;
    localparam idx_t POS_SEP_HI = 3'd5;
    localparam idx_t POS_HOUR_D = 3'd6;
    localparam idx_t POS_HOUR_G = 3'd7;

    // Active-low segment patterns, bit 0 = a .. bit 6 = g.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_SEP   = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h06;

    function automatic logic is_sep(input idx_t pos);
        return (pos == POS_SEP_LO) || (pos == POS_SEP_HI);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment pattern; values 10..15 show 'E'.
module bcd_to_seg7
    import seg_scan_pkg::*;
(
    input  digit_t           value_i,
    output logic [SEG_W-1:0] seg_c_o
);

    // Pure lookup, no state.
    always_comb begin
        seg_c_o = SEG_E;
        case (value_i)
            4'd0:    seg_c_o = 7'h40;
            4'd1:    seg_c_o = 7'h79;
            4'd2:    seg_c_o = 7'h24;
            4'd3:    seg_c_o = 7'h30;
            4'd4:    seg_c_o = 7'h19;
            4'd5:    seg_c_o = 7'h12;
            4'd6:    seg_c_o = 7'h02;
            4'd7:    seg_c_o = 7'h78;
            4'd8:    seg_c_o = 7'h00;
            4'd9:    seg_c_o = 7'h10;
            default: seg_c_o = SEG_E;
        endcase
    end

endmodule

// File: rtl/seg_scan.sv
// Eight-position display scanner for the HH-MM-SS clock.
// Optional macro SEG_SCAN_BLINK_EN: blink the selected digit in set mode
// instead of lighting its decimal point.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic             CLK_50MHz,
    input  logic             reset,
    input  digit_t           second_d,
    input  digit_t           second_g,
    input  digit_t           minute_d,
    input  digit_t           minute_g,
    input  digit_t           hour_d,
    input  digit_t           hour_g,
    input  logic [IDX_W-1:0] select,
    input  logic             select_enable,
    output logic [POS_N-1:0] dig_sel,
    output logic [SEG_W-1:0] seg,
    output logic             dp
);

    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_bad_div
        $error("seg_scan: SCAN_DIV and BLINK_DIV must be at least 2");
    end

    logic [PRE_W-1:0] pre_q, pre_d;
    idx_t             idx_q, idx_d;
    logic [POS_N-1:0] dig_sel_q, dig_sel_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick;
    digit_t           digit;
    logic [SEG_W-1:0] dec_seg;
    logic             sel_hit;
    logic             blank_msd;

    // Slot prescaler and position walk; the enable moves on the tick edge.
    always_comb begin
        tick      = (pre_q == PRE_W'(SCAN_DIV - 1));
        pre_d     = tick ? '0 : pre_q + PRE_W'(1);
        idx_d     = tick ? idx_q + IDX_W'(1) : idx_q;
        dig_sel_d = tick ? ~(POS_N'(1) << idx_d) : dig_sel_q;
    end

    // Digit routed to the position being presented after this edge.
    always_comb begin
        digit = '0;
        case (idx_d)
            POS_SEC_D:  digit = second_d;
            POS_SEC_G:  digit = second_g;
            POS_MIN_D:  digit = minute_d;
            POS_MIN_G:  digit = minute_g;
            POS_HOUR_D: digit = hour_d;
            POS_HOUR_G: digit = hour_g;
            default:    digit = '0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .value_i (digit),
        .seg_c_o (dec_seg)
    );

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               hidden_q, hidden_d;

    // Blink half-period timer; idles visible outside set mode.
    always_comb begin
        blink_d  = '0;
        hidden_d = 1'b0;
        if (select_enable) begin
            if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_d  = '0;
                hidden_d = ~hidden_q;
            end else begin
                blink_d  = blink_q + BLINK_W'(1);
                hidden_d = hidden_q;
            end
        end
    end

    // Blink timer state.
    always_ff @(posedge CLK_50MHz or negedge reset) begin
        if (!reset) begin
            blink_q  <= '0;
            hidden_q <= 1'b0;
        end else begin
            blink_q  <= blink_d;
            hidden_q <= hidden_d;
        end
    end
`endif

    // Segment/decimal-point selection; separators never blink or take dp.
    always_comb begin
        sel_hit = select_enable && (select == idx_d) && !is_sep(idx_d);
`ifdef SEG_SCAN_BLINK_EN
        blank_msd = (idx_d == POS_HOUR_G) && (hour_g == '0) && !sel_hit;
        dp_d      = 1'b1;
        seg_d     = dec_seg;
        if (is_sep(idx_d)) begin
            seg_d = SEG_SEP;
        end else if ((sel_hit && hidden_q) || blank_msd) begin
            seg_d = SEG_BLANK;
        end
`else
        blank_msd = (idx_d == POS_HOUR_G) && (hour_g == '0);
        dp_d      = !sel_hit;
        seg_d     = dec_seg;
        if (is_sep(idx_d)) begin
            seg_d = SEG_SEP;
        end else if (blank_msd) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    // Scan state and registered display outputs.
    always_ff @(posedge CLK_50MHz or negedge reset) begin
        if (!reset) begin
            pre_q     <= '0;
            idx_q     <= POS_HOUR_G;
            dig_sel_q <= '1;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            dig_sel_q <= dig_sel_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign dig_sel = dig_sel_q;
    assign seg     = seg_q;
    assign dp      = dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: driver pushes expected outputs per edge,
// monitor pops and compares after each rising edge.
module tb_seg_scan;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned BLINK_DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sd, sg, md, mg, hd, hg;
    logic [2:0] sel;
    logic       sel_en;
    logic [7:0] dig_sel;
    logic [6:0] seg;
    logic       dp;

    int compared   = 0;
    int mismatched = 0;
    int k = 0;
    int m = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .CLK_50MHz     (clk),
        .reset         (rst_n),
        .second_d      (sd),
        .second_g      (sg),
        .minute_d      (md),
        .minute_g      (mg),
        .hour_d        (hd),
        .hour_g        (hg),
        .select        (sel),
        .select_enable (sel_en),
        .dig_sel       (dig_sel),
        .seg           (seg),
        .dp            (dp)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
        end
    endtask

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h06;
        endcase
    endfunction

    // Expected {dig_sel, seg, dp} for rising edge number k after reset release;
    // m is the number of preceding consecutive edges spent in set mode.
    function automatic logic [15:0] model();
        int p;
        logic [7:0] ds;
        logic [6:0] s;
        logic d, here, hide, blank7;
        logic [3:0] v;
        if (k < SCAN_DIV) begin
            ds = 8'hFF;
            p  = 7;
        end else begin
            p  = ((k / SCAN_DIV) - 1) % 8;
            ds = ~(8'(1) << p);
        end
        case (p)
            0: v = sd;
            1: v = sg;
            3: v = md;
            4: v = mg;
            6: v = hd;
            7: v = hg;
            default: v = 4'd0;
        endcase
        here = sel_en && (int'(sel) == p) && (p != 2) && (p != 5);
`ifdef SEG_SCAN_BLINK_EN
        hide   = here && (((m / BLINK_DIV) % 2) == 1);
        blank7 = (p == 7) && (hg == 4'd0) && !here;
        d      = 1'b1;
`else
        hide   = 1'b0;
        blank7 = (p == 7) && (hg == 4'd0);
        d      = !here;
`endif
        if (p == 2 || p == 5)   s = 7'h3F;
        else if (hide || blank7) s = 7'h7F;
        else                     s = decode(v);
        return {ds, s, d};
    endfunction

    task automatic push();
        if (!rst_n) begin
            k = 0;
            m = 0;
            exp_q.push_back({8'hFF, 7'h7F, 1'b1});
        end else begin
            k++;
            exp_q.push_back(model());
            m = sel_en ? m + 1 : 0;
        end
    endtask

    // Called at a falling edge with inputs already set for the next rising edge.
    task automatic run(input int n);
        repeat (n) begin
            push();
            @(negedge clk);
        end
    endtask

    // Monitor: compare each registered output against the scoreboard head.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out{dig_sel,seg,dp}", {16'h0, dig_sel, seg, dp}, {16'h0, e});
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        sd = 4'd1; sg = 4'd2; md = 4'd3; mg = 4'd4; hd = 4'd5; hg = 4'd6;
        sel = 3'd0; sel_en = 1'b0;
        @(negedge clk);
        chk("reset_dig_sel", {24'h0, dig_sel}, 32'hFF);
        chk("reset_seg", {25'h0, seg}, 32'h7F);
        chk("reset_dp", {31'h0, dp}, 32'h1);
        run(3);

        rst_n = 1'b1;  run(40);
        hg = 4'd0;     run(40);
        hg = 4'd12;    run(40);
        hg = 4'd0; sel = 3'd7; sel_en = 1'b1; run(40);
        hg = 4'd6; sel = 3'd4; run(48);
        sel_en = 1'b0; run(8);
        sel = 3'd2; sel_en = 1'b1; run(40);
        sel = 3'd6; run(40);
        sel_en = 1'b0; run(8);

        repeat (600) begin
            if ($urandom_range(15) == 0) begin
                sd = 4'($urandom_range(15));
                sg = 4'($urandom_range(15));
                md = 4'($urandom_range(15));
                mg = 4'($urandom_range(15));
                hd = 4'($urandom_range(15));
                hg = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15));
            end
            if ($urandom_range(31) == 0) sel_en = ~sel_en;
            if ($urandom_range(19) == 0) sel = 3'($urandom_range(7));
            run(1);
        end

        // Reset in the middle of the position-5 slot.
        guard = 0;
        while (!(k >= SCAN_DIV && (((k / SCAN_DIV) - 1) % 8) == 5 && (k % SCAN_DIV) == 1)
               && guard < 200) begin
            run(1);
            guard++;
        end
        chk("reach_pos5_slot", {24'h0, dig_sel}, 32'hDF);
        rst_n = 1'b0;
        #1;
        chk("midslot_reset_dig_sel", {24'h0, dig_sel}, 32'hFF);
        chk("midslot_reset_seg", {25'h0, seg}, 32'h7F);
        run(3);
        rst_n = 1'b1;
        run(40);

        run(1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
